// File: rtl/core_pkg.sv
// Shared core types: the dispatch micro-op, its functional-unit tag and the
// default dispatch queue depth.
package core_pkg;

    localparam int DISP_Q_DEPTH = 8;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MEM = 2'd1,
        FU_BR  = 2'd2
    } FU_TYPE_e;

    // fu_type sits in the top bits so the steering field is easy to spot in dumps.
    typedef struct packed {
        FU_TYPE_e    fu_type;
        logic [5:0]  rob_tag;
        logic [23:0] payload;
    } Disp_uOP;

endpackage

// File: rtl/dispatch_ctrl_if.sv
// Rename -> dispatch -> reservation-station signal bundle. The master side
// is Rename plus the three reservation stations; the slave side is dispatch_ctrl.
interface dispatch_ctrl_if #(
    parameter int DEPTH   = 8,
    parameter int STALL_W = 16
);
    import core_pkg::*;

    Disp_uOP                  instr_uop;
    logic                     instr_valid;
    logic                     queue_full;
    logic                     flush;

    Disp_uOP                  alu_uop;
    Disp_uOP                  mem_uop;
    Disp_uOP                  br_uop;
    logic                     alu_valid;
    logic                     mem_valid;
    logic                     br_valid;
    logic                     alu_ready;
    logic                     mem_ready;
    logic                     br_ready;

    logic [STALL_W-1:0]       stall_cnt;
    logic [$clog2(DEPTH):0]   occupancy;

    modport master (
        output instr_uop, instr_valid, flush, alu_ready, mem_ready, br_ready,
        input  queue_full, alu_uop, mem_uop, br_uop,
               alu_valid, mem_valid, br_valid, stall_cnt, occupancy
    );

    modport slave (
        input  instr_uop, instr_valid, flush, alu_ready, mem_ready, br_ready,
        output queue_full, alu_uop, mem_uop, br_uop,
               alu_valid, mem_valid, br_valid, stall_cnt, occupancy
    );

endinterface

// File: rtl/uop_fifo.sv
// In-order circular uop store. Pointers wrap naturally because DEPTH is a
// power of two; head data is read straight out of the storage registers.
module uop_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = DISP_Q_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  Disp_uOP                push_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output Disp_uOP                head_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    Disp_uOP         mem_reg [DEPTH];
    logic [PW-1:0]   head_reg;
    logic [PW-1:0]   tail_reg;
    logic [CW-1:0]   count_reg;
    logic            do_push;
    logic            do_pop;

    // Guard the raw requests so the store can never overrun or underrun;
    // flush suppresses both.
    always_comb begin
        do_push = push && !full && !flush;
        do_pop  = pop && !empty && !flush;
    end

    // Pointer and occupancy bookkeeping; reset beats flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (do_push) tail_reg <= tail_reg + PW'(1);
            if (do_pop)  head_reg <= head_reg + PW'(1);
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage write; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (do_push) mem_reg[tail_reg] <= push_data;
    end

    assign head_data = mem_reg[head_reg];
    assign count     = count_reg;
    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CW'(DEPTH));

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch queue between Rename and the ALU/MEM/BR reservation stations:
// in-order FIFO, head steering by fu_type, and a saturating stall counter.
module dispatch_ctrl
    import core_pkg::*;
#(
    parameter int DEPTH   = DISP_Q_DEPTH,
    parameter int STALL_W = 16
) (
    input logic            clk,
    input logic            rst,
    dispatch_ctrl_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      count;
    Disp_uOP            head_uop;

    logic               sel_mem;
    logic               sel_br;
    logic               sel_alu;
    logic               sel_ready;
    logic               offer;
    logic [STALL_W-1:0] stall_cnt_reg;
    logic [STALL_W-1:0] stall_cnt_next;

    uop_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (bus.flush),
        .push_data (bus.instr_uop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count),
        .head_data (head_uop)
    );

    // Steer the head to one station; unknown fu_type codes fall back to ALU.
    // Valids depend only on stored state and flush, never on any ready.
    always_comb begin
        sel_mem   = (head_uop.fu_type == FU_MEM);
        sel_br    = (head_uop.fu_type == FU_BR);
        sel_alu   = !sel_mem && !sel_br;
        offer     = !fifo_empty && !bus.flush;
        sel_ready = bus.alu_ready;
        if (sel_mem)     sel_ready = bus.mem_ready;
        else if (sel_br) sel_ready = bus.br_ready;

        bus.alu_valid = offer && sel_alu;
        bus.mem_valid = offer && sel_mem;
        bus.br_valid  = offer && sel_br;
        bus.alu_uop   = head_uop;
        bus.mem_uop   = head_uop;
        bus.br_uop    = head_uop;

        pop  = offer && sel_ready;
        push = bus.instr_valid && !fifo_full && !bus.flush;

        stall_cnt_next = stall_cnt_reg;
        if (offer && !sel_ready && (stall_cnt_reg != '1))
            stall_cnt_next = stall_cnt_reg + STALL_W'(1);
    end

    // Stall counter register; flush leaves it alone because offer is low.
    always_ff @(posedge clk) begin
        if (rst) stall_cnt_reg <= '0;
        else     stall_cnt_reg <= stall_cnt_next;
    end

    assign bus.queue_full = fifo_full;
    assign bus.occupancy  = count;
    assign bus.stall_cnt  = stall_cnt_reg;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Bench for dispatch_ctrl: two instances (16-bit and 4-bit stall counters)
// share one stimulus stream and are checked against a queue-based model.
module tb_dispatch_ctrl;
    import core_pkg::*;

    localparam int DEPTH = 8;

    logic    clk = 1'b0;
    logic    rst;
    logic    t_rst, t_valid, t_flush, t_ar, t_mr, t_br;
    Disp_uOP t_uop;

    int      total = 0;
    int      bad   = 0;

    // Reference model state
    Disp_uOP q[$];
    int      st16 = 0;
    int      st4  = 0;

    always #5 clk = ~clk;

    dispatch_ctrl_if #(.DEPTH(DEPTH), .STALL_W(16)) bus ();
    dispatch_ctrl_if #(.DEPTH(DEPTH), .STALL_W(4))  bus4 ();

    assign rst              = t_rst;
    assign bus.instr_uop    = t_uop;
    assign bus.instr_valid  = t_valid;
    assign bus.flush        = t_flush;
    assign bus.alu_ready    = t_ar;
    assign bus.mem_ready    = t_mr;
    assign bus.br_ready     = t_br;
    assign bus4.instr_uop   = t_uop;
    assign bus4.instr_valid = t_valid;
    assign bus4.flush       = t_flush;
    assign bus4.alu_ready   = t_ar;
    assign bus4.mem_ready   = t_mr;
    assign bus4.br_ready    = t_br;

    dispatch_ctrl #(.DEPTH(DEPTH), .STALL_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dispatch_ctrl #(.DEPTH(DEPTH), .STALL_W(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    function automatic Disp_uOP mk(input logic [1:0] fu);
        Disp_uOP u;
        u.fu_type = FU_TYPE_e'(fu);
        u.rob_tag = 6'($urandom);
        u.payload = 24'($urandom);
        return u;
    endfunction

    // Expected {alu,mem,br} valids from model contents and current flush.
    function automatic logic [2:0] exp_sel();
        if (q.size() == 0 || t_flush) return 3'b000;
        case (q[0].fu_type)
            FU_MEM:  return 3'b010;
            FU_BR:   return 3'b001;
            default: return 3'b100;
        endcase
    endfunction

    // Apply the current inputs to the model as one clock edge.
    task automatic model_step();
        bit full_now = (q.size() == DEPTH);
        bit deq = 0;
        bit enq;
        bit rdy;
        if (t_rst) begin
            q.delete();
            st16 = 0;
            st4  = 0;
            return;
        end
        if (q.size() > 0 && !t_flush) begin
            rdy = (q[0].fu_type == FU_MEM) ? t_mr : (q[0].fu_type == FU_BR) ? t_br : t_ar;
            if (rdy) deq = 1;
            else begin
                st16 = (st16 < 65535) ? st16 + 1 : 65535;
                st4  = (st4 < 15) ? st4 + 1 : 15;
            end
        end
        enq = t_valid && !full_now && !t_flush;
        if (t_flush) q.delete();
        else begin
            if (deq) void'(q.pop_front());
            if (enq) q.push_back(t_uop);
        end
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        t_valid = 0; t_flush = 0; t_ar = 0; t_mr = 0; t_br = 0; t_uop = '0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        t_rst = 1;
        advance();
        t_rst = 0;
    endtask

    task automatic test_reset();
        reset_dut();
        @(negedge clk);
        total++;
        if (bus.occupancy !== 4'd0 || bus.queue_full !== 1'b0)
            begin bad++; $display("FAIL reset_occ: occ=%0d full=%b want 0/0", bus.occupancy, bus.queue_full); end
        total++;
        if ({bus.alu_valid, bus.mem_valid, bus.br_valid} !== 3'b000)
            begin bad++; $display("FAIL reset_valid: got %b want 000", {bus.alu_valid, bus.mem_valid, bus.br_valid}); end
        total++;
        if (bus.stall_cnt !== 16'd0 || bus4.stall_cnt !== 4'd0)
            begin bad++; $display("FAIL reset_stall: got %0d/%0d want 0", bus.stall_cnt, bus4.stall_cnt); end
        $display("test_reset done");
    endtask

    task automatic test_alu_stream();
        Disp_uOP sent[3];
        reset_dut();
        t_ar = 1;
        for (int i = 0; i < 5; i++) begin
            t_valid = (i < 3);
            if (i < 3) begin sent[i] = mk(2'd0); t_uop = sent[i]; end
            @(negedge clk);
            total++;
            if (i == 0 || i == 4) begin
                if (bus.alu_valid !== 1'b0)
                    begin bad++; $display("FAIL stream_idle[%0d]: alu_valid=%b want 0", i, bus.alu_valid); end
            end else if (bus.alu_valid !== 1'b1 || bus.alu_uop !== sent[i-1]) begin
                bad++;
                $display("FAIL stream_order[%0d]: v=%b uop=%h want 1/%h", i, bus.alu_valid, bus.alu_uop, sent[i-1]);
            end
            advance();
        end
        total++;
        if (bus.occupancy !== 4'd0)
            begin bad++; $display("FAIL stream_occ: got %0d want 0", bus.occupancy); end
        $display("test_alu_stream done");
    endtask

    task automatic test_fill();
        Disp_uOP first;
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            t_valid = 1;
            t_uop = mk(2'($urandom_range(0, 2)));
            if (i == 0) first = t_uop;
            advance();
        end
        total++;
        if (bus.queue_full !== 1'b1 || bus.occupancy !== 4'd8)
            begin bad++; $display("FAIL fill_full: full=%b occ=%0d want 1/8", bus.queue_full, bus.occupancy); end
        t_uop = mk(2'd0);
        advance();
        t_valid = 0;
        @(negedge clk);
        total++;
        if (bus.occupancy !== 4'd8 || bus.alu_uop !== first)
            begin bad++; $display("FAIL fill_ignore: occ=%0d head=%h want 8/%h", bus.occupancy, bus.alu_uop, first); end
        $display("test_fill done");
    endtask

    task automatic test_blocked_head();
        Disp_uOP m, a;
        reset_dut();
        m = mk(2'd1);
        a = mk(2'd0);
        t_valid = 1; t_uop = m;
        advance();
        t_uop = a;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (bus.alu_valid !== 1'b0 || bus.mem_valid !== 1'b1 || bus.mem_uop !== m)
                begin bad++; $display("FAIL blocked[%0d]: alu_v=%b mem_v=%b want 0/1", i, bus.alu_valid, bus.mem_valid); end
            advance();
            t_valid = 0;
        end
        total++;
        if (bus.stall_cnt !== 16'd5 || st16 != 5)
            begin bad++; $display("FAIL blocked_stall: got %0d want 5", bus.stall_cnt); end
        t_mr = 1; t_ar = 1;
        @(negedge clk);
        total++;
        if (bus.mem_valid !== 1'b1 || bus.mem_uop !== m)
            begin bad++; $display("FAIL blocked_mem: v=%b uop=%h want 1/%h", bus.mem_valid, bus.mem_uop, m); end
        advance();
        @(negedge clk);
        total++;
        if (bus.alu_valid !== 1'b1 || bus.alu_uop !== a)
            begin bad++; $display("FAIL blocked_alu: v=%b uop=%h want 1/%h", bus.alu_valid, bus.alu_uop, a); end
        advance();
        total++;
        if (bus.occupancy !== 4'd0 || bus.stall_cnt !== 16'd5)
            begin bad++; $display("FAIL blocked_drain: occ=%0d stall=%0d want 0/5", bus.occupancy, bus.stall_cnt); end
        $display("test_blocked_head done");
    endtask

    task automatic test_flush();
        int stall_before;
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            t_valid = 1; t_uop = mk(2'($urandom_range(0, 2)));
            advance();
        end
        stall_before = st16;
        t_valid = 1; t_flush = 1; t_uop = mk(2'd0);
        @(negedge clk);
        total++;
        if ({bus.alu_valid, bus.mem_valid, bus.br_valid} !== 3'b000)
            begin bad++; $display("FAIL flush_same: valids=%b want 000", {bus.alu_valid, bus.mem_valid, bus.br_valid}); end
        advance();
        t_valid = 0; t_flush = 0;
        @(negedge clk);
        total++;
        if (bus.occupancy !== 4'd0 || {bus.alu_valid, bus.mem_valid, bus.br_valid} !== 3'b000)
            begin bad++; $display("FAIL flush_next: occ=%0d valids=%b want 0/000", bus.occupancy, {bus.alu_valid, bus.mem_valid, bus.br_valid}); end
        total++;
        if (bus.stall_cnt !== 16'(stall_before))
            begin bad++; $display("FAIL flush_stall: got %0d want %0d", bus.stall_cnt, stall_before); end
        $display("test_flush done");
    endtask

    task automatic test_full_deq_wrap();
        Disp_uOP x;
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            t_valid = 1; t_uop = mk(2'd0);
            advance();
        end
        x = mk(2'd0);
        t_uop = x; t_ar = 1;
        advance();
        total++;
        if (bus.occupancy !== 4'd7)
            begin bad++; $display("FAIL full_deq_occ: got %0d want 7", bus.occupancy); end
        t_valid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (bus.alu_uop !== q[0] || bus.alu_uop === x)
                begin bad++; $display("FAIL full_deq_head[%0d]: got %h want %h", i, bus.alu_uop, q[0]); end
            advance();
        end
        for (int i = 0; i < 20; i++) begin
            t_valid = 1; t_uop = mk(2'd0);
            @(negedge clk);
            total++;
            if (bus.alu_valid !== 1'b1 || bus.alu_uop !== q[0] || bus.occupancy !== 4'(q.size()))
                begin bad++; $display("FAIL wrap[%0d]: uop=%h occ=%0d want %h/%0d", i, bus.alu_uop, bus.occupancy, q[0], q.size()); end
            advance();
        end
        total++;
        if (bus.occupancy !== 4'd3)
            begin bad++; $display("FAIL wrap_occ: got %0d want 3", bus.occupancy); end
        $display("test_full_deq_wrap done");
    endtask

    task automatic test_steer_sat();
        reset_dut();
        t_valid = 1; t_uop = mk(2'd3);
        advance();
        t_uop = mk(2'd2);
        @(negedge clk);
        total++;
        if ({bus.alu_valid, bus.mem_valid, bus.br_valid} !== 3'b100 || bus.alu_uop !== q[0])
            begin bad++; $display("FAIL steer_unknown: valids=%b want 100", {bus.alu_valid, bus.mem_valid, bus.br_valid}); end
        t_ar = 1;
        advance();
        t_valid = 0; t_ar = 0; t_uop = mk(2'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (bus.br_valid !== 1'b1 || bus.br_uop !== q[0])
                begin bad++; $display("FAIL steer_br[%0d]: v=%b want 1", i, bus.br_valid); end
            advance();
        end
        total++;
        if (bus4.stall_cnt !== 4'd15 || st4 != 15)
            begin bad++; $display("FAIL stall_sat4: got %0d want 15", bus4.stall_cnt); end
        total++;
        if (bus.stall_cnt !== 16'd20)
            begin bad++; $display("FAIL stall_wide: got %0d want 20", bus.stall_cnt); end
        $display("test_steer_sat done");
    endtask

    task automatic test_mid_reset();
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            t_valid = 1; t_uop = mk(2'($urandom_range(0, 2)));
            advance();
        end
        t_rst = 1; t_ar = 1; t_mr = 1; t_br = 1;
        advance();
        t_rst = 0; t_valid = 0;
        @(negedge clk);
        total++;
        if (bus.occupancy !== 4'd0 || {bus.alu_valid, bus.mem_valid, bus.br_valid} !== 3'b000 || bus.stall_cnt !== 16'd0)
            begin bad++; $display("FAIL mid_reset: occ=%0d stall=%0d want 0/0", bus.occupancy, bus.stall_cnt); end
        $display("test_mid_reset done");
    endtask

    task automatic test_random();
        reset_dut();
        for (int c = 0; c < 600; c++) begin
            t_rst   = ($urandom_range(0, 149) == 0);
            t_flush = ($urandom_range(0, 39) == 0);
            t_valid = ($urandom_range(0, 2) != 0);
            t_uop   = mk(2'($urandom_range(0, 3)));
            t_ar    = ($urandom_range(0, 2) != 0);
            t_mr    = ($urandom_range(0, 1) != 0);
            t_br    = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            total++;
            if ({bus.alu_valid, bus.mem_valid, bus.br_valid} !== exp_sel())
                begin bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, {bus.alu_valid, bus.mem_valid, bus.br_valid}, exp_sel()); end
            total++;
            if (bus.occupancy !== 4'(q.size()) || bus.queue_full !== (q.size() == DEPTH))
                begin bad++; $display("FAIL rnd_occ[%0d]: occ=%0d full=%b want %0d", c, bus.occupancy, bus.queue_full, q.size()); end
            total++;
            if (bus.stall_cnt !== 16'(st16) || bus4.stall_cnt !== 4'(st4))
                begin bad++; $display("FAIL rnd_stall[%0d]: got %0d/%0d want %0d/%0d", c, bus.stall_cnt, bus4.stall_cnt, st16, st4); end
            if (q.size() > 0) begin
                total++;
                if (bus.alu_uop !== q[0] || bus.mem_uop !== q[0] || bus.br_uop !== q[0])
                    begin bad++; $display("FAIL rnd_head[%0d]: got %h want %h", c, bus.alu_uop, q[0]); end
            end
            advance();
        end
        t_rst = 0;
        $display("test_random done");
    endtask

    initial begin
        t_rst = 1;
        idle_inputs();
        test_reset();
        test_alu_stream();
        test_fill();
        test_blocked_head();
        test_flush();
        test_full_deq_wrap();
        test_steer_sat();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
